// File: rtl/serial_link_n.sv
// serial_link_n
//   A sender and a receiver joined by a 4-phase rdy/ack handshake and a
//   1-bit serial data line, in one block. The sender frames a WIDTH-bit word
//   (plus an optional even-parity bit), raises rdyo, waits for acko, shifts
//   the frame out LSB first, then waits for acko to drop. The receiver
//   acknowledges, captures the bits, and reports the word with a valid pulse.
//   If acko never arrives within TIMEOUT cycles the sender abandons the request.
//
//   Handshake semantics: rdyo means "the sender holds a frame for you"; acko
//   means "the receiver has committed to this frame". The sender starts
//   shifting only on the edge it sees acko=1, and returns to idle only once
//   acko has dropped again. All outputs come straight from flops.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   load     in   start request (ignored while busy)
//   datain   in   word to send, captured on the accepting edge
//   inj_err  in   captured with datain; inverts the transmitted parity bit
//   rx_en    in   receiver may acknowledge a new frame
//   busy     out  sender not idle
//   dataout  out  last received word
//   valid    out  one-cycle pulse, dataout updated
//   error    out  parity mismatch on last frame (sticky until next load)
//   timeout  out  last request abandoned (sticky until next load)
//   rdyo     out  sender request line
//   acko     out  receiver acknowledge line
//   datao    out  serial data, LSB first
//   shifts   out  sender shift strobe
//   shiftr   out  high the cycle after each receiver capture
//   ys       out  sender state (IDLE=0, REQ=1, SHIFT=2, WAIT=3)
//   yr       out  receiver state (IDLE=0, RECV=1, DONE=2)

module serial_link_n #(
    parameter int WIDTH   = 3,
    parameter int PARITY  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] datain,
    input  logic             inj_err,
    input  logic             rx_en,
    output logic             busy,
    output logic [WIDTH-1:0] dataout,
    output logic             valid,
    output logic             error,
    output logic             timeout,
    output logic             rdyo,
    output logic             acko,
    output logic             datao,
    output logic             shifts,
    output logic             shiftr,
    output logic [2:0]       ys,
    output logic [1:0]       yr
);

    localparam int NB   = WIDTH + PARITY;
    localparam int CMAX = (TIMEOUT > NB) ? TIMEOUT : NB;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RCW  = $clog2(NB + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3
    } s_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_RECV = 2'd1,
        R_DONE = 2'd2
    } r_state_t;

    // Sender registers
    s_state_t          ys_q, ys_d;
    logic [CW-1:0]     scnt_q, scnt_d;     // REQ wait counter, then SHIFT bit counter
    logic [NB-1:0]     frame_q, frame_d;
    logic              rdyo_q, rdyo_d;
    logic              shifts_q, shifts_d;
    logic              datao_q, datao_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic              clr_err;

    // Receiver registers
    r_state_t          yr_q, yr_d;
    logic [RCW-1:0]    rcnt_q, rcnt_d;
    logic [NB-1:0]     rsh_q, rsh_d;
    logic              acko_q, acko_d;
    logic              shiftr_q, shiftr_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  dataout_q, dataout_d;
    logic              error_q, error_d;

    // Frame as loaded: data in the low bits, parity (if any) on top so it
    // leaves last.
    logic [NB-1:0]     frame_load;

    always_comb begin
        frame_load = '0;
        frame_load[WIDTH-1:0] = datain;
        if (PARITY != 0) begin
            frame_load[NB-1] = (^datain) ^ inj_err;
        end
    end

    // ------------------------------------------------------------------
    // Sender FSM
    // ------------------------------------------------------------------
    always_comb begin
        ys_d      = ys_q;
        scnt_d    = scnt_q;
        frame_d   = frame_q;
        datao_d   = 1'b0;
        timeout_d = timeout_q;
        clr_err   = 1'b0;
        case (ys_q)
            S_IDLE: begin
                if (load) begin
                    frame_d   = frame_load;
                    scnt_d    = '0;
                    timeout_d = 1'b0;
                    clr_err   = 1'b1;
                    ys_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (acko_q) begin
                    // First bit goes out together with the move to SHIFT.
                    datao_d = frame_q[0];
                    frame_d = frame_q >> 1;
                    scnt_d  = CW'(1);
                    ys_d    = S_SHIFT;
                end else if (scnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    ys_d      = S_IDLE;
                end else begin
                    scnt_d = scnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (scnt_q == CW'(NB)) begin
                    ys_d = S_WAIT;
                end else begin
                    datao_d = frame_q[0];
                    frame_d = frame_q >> 1;
                    scnt_d  = scnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (!acko_q) begin
                    ys_d = S_IDLE;
                end
            end
            default: begin
                ys_d = S_IDLE;
            end
        endcase
        rdyo_d   = (ys_d == S_REQ);
        shifts_d = (ys_d == S_SHIFT);
        busy_d   = (ys_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    always_comb begin
        yr_d      = yr_q;
        rcnt_d    = rcnt_q;
        rsh_d     = rsh_q;
        dataout_d = dataout_q;
        error_d   = clr_err ? 1'b0 : error_q;
        shiftr_d  = 1'b0;
        case (yr_q)
            R_IDLE: begin
                if (rdyo_q && rx_en) begin
                    rcnt_d = '0;
                    yr_d   = R_RECV;
                end
            end
            R_RECV: begin
                if (shifts_q) begin
                    rsh_d         = rsh_q >> 1;
                    rsh_d[NB-1]   = datao_q;
                    shiftr_d      = 1'b1;
                    rcnt_d        = rcnt_q + RCW'(1);
                    if (rcnt_q == RCW'(NB - 1)) begin
                        dataout_d = rsh_d[WIDTH-1:0];
                        // Even parity: XOR over data plus parity bit is 0.
                        error_d   = (PARITY != 0) ? (^rsh_d) : 1'b0;
                        yr_d      = R_DONE;
                    end
                end else if ((rcnt_q == '0) && !rdyo_q) begin
                    // Sender timed out on the same edge we acknowledged.
                    yr_d = R_IDLE;
                end
            end
            R_DONE: begin
                yr_d = R_IDLE;
            end
            default: begin
                yr_d = R_IDLE;
            end
        endcase
        acko_d  = (yr_d == R_RECV);
        valid_d = (yr_d == R_DONE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ys_q      <= S_IDLE;
            scnt_q    <= '0;
            frame_q   <= '0;
            rdyo_q    <= 1'b0;
            shifts_q  <= 1'b0;
            datao_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            yr_q      <= R_IDLE;
            rcnt_q    <= '0;
            rsh_q     <= '0;
            acko_q    <= 1'b0;
            shiftr_q  <= 1'b0;
            valid_q   <= 1'b0;
            dataout_q <= '0;
            error_q   <= 1'b0;
        end else begin
            ys_q      <= ys_d;
            scnt_q    <= scnt_d;
            frame_q   <= frame_d;
            rdyo_q    <= rdyo_d;
            shifts_q  <= shifts_d;
            datao_q   <= datao_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            yr_q      <= yr_d;
            rcnt_q    <= rcnt_d;
            rsh_q     <= rsh_d;
            acko_q    <= acko_d;
            shiftr_q  <= shiftr_d;
            valid_q   <= valid_d;
            dataout_q <= dataout_d;
            error_q   <= error_d;
        end
    end

    assign busy    = busy_q;
    assign dataout = dataout_q;
    assign valid   = valid_q;
    assign error   = error_q;
    assign timeout = timeout_q;
    assign rdyo    = rdyo_q;
    assign acko    = acko_q;
    assign datao   = datao_q;
    assign shifts  = shifts_q;
    assign shiftr  = shiftr_q;
    assign ys      = ys_q;
    assign yr      = yr_q;

endmodule
